afe_serial_cfg: RTL

Register-write sequencer for the AD9945 analog front end used beside the TCD1209D line-sensor driver. It snapshots the four AFE configuration fields (oper, ctrl, clamp, vga_gain) when a configuration is requested. It then writes the selected fields as 3-wire serial words on SL/SCK/SDATA and reports busy/done to the capture logic. The block runs in the sensor system clock domain and is the only driver of the AFE serial pins.

---
 rtl/afe_serial_cfg.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/afe_serial_cfg.sv
// -----------------------------------------------------------------------------
// afe_serial_cfg
//
// Register-write sequencer for the AD9945 AFE 3-wire serial port. A rising
// edge on cfg_en snapshots the four configuration fields and cfg_mask, then
// each masked address (ascending) is written as a 14-bit word
// {11-bit zero-extended data, 3-bit address}, LSB first.
//
// Parameters:
//   CLK_DIV  SCK half-period in sys_clk cycles (>=1)
//   SL_GAP   sys_clk cycles SL stays high between words (>=1)
//
// Ports:
//   sys_clk   system clock, rising edge
//   reset     asynchronous, active-high reset
//   oper      operation register value   (address 0)
//   ctrl      control register value     (address 1)
//   clamp     clamp level                (address 2)
//   vga_gain  VGA gain                   (address 3)
//   cfg_mask  bit n set = write address n
//   cfg_en    configuration request, rising edge starts a sequence
//   cfg_busy  high from sequence start through the done cycle
//   cfg_done  one-cycle pulse at sequence completion
//   SL        serial load, low while a word is being shifted
//   SCK       serial clock, idles low
//   SDATA     serial data
// -----------------------------------------------------------------------------
module afe_serial_cfg #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned SL_GAP  = 4
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [6:0] oper,
  input  logic [6:0] ctrl,
  input  logic [7:0] clamp,
  input  logic [9:0] vga_gain,
  input  logic [3:0] cfg_mask,
  input  logic       cfg_en,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       SL,
  output logic       SCK,
  output logic       SDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  localparam int unsigned CNT_MAX = (CLK_DIV > SL_GAP) ? CLK_DIV : SL_GAP;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SL_GAP - 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [3:0]  bit_idx;
  logic [13:0] sr;
  logic [3:0]  rem_mask;
  logic        pending;

  logic [6:0]  snap_oper;
  logic [6:0]  snap_ctrl;
  logic [7:0]  snap_clamp;
  logic [9:0]  snap_gain;

  logic        en_q;
  logic        en_prev;
  logic        rise_q;

  logic [1:0]  start_addr;
  logic [1:0]  next_addr;
  logic [13:0] start_word;
  logic [13:0] next_word;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    logic [1:0] r;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else           r = 2'd3;
    return r;
  endfunction

  function automatic logic [13:0] make_word(input logic [1:0] addr,
                                            input logic [6:0] o,
                                            input logic [6:0] c,
                                            input logic [7:0] cl,
                                            input logic [9:0] g);
    logic [10:0] data;
    case (addr)
      2'd0:    data = {4'b0000, o};
      2'd1:    data = {4'b0000, c};
      2'd2:    data = {3'b000, cl};
      default: data = {1'b0, g};
    endcase
    return {data, 1'b0, addr};
  endfunction

  // The first word of a sequence is built from the live inputs on the same
  // edge that captures the snapshot; later words come from the snapshot.
  always_comb begin
    start_addr = lowest(cfg_mask);
    next_addr  = lowest(rem_mask);
    start_word = make_word(start_addr, oper, ctrl, clamp, vga_gain);
    next_word  = make_word(next_addr, snap_oper, snap_ctrl, snap_clamp, snap_gain);
  end

  // Request synchroniser and registered edge detect.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b0;
      en_prev <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      en_q    <= cfg_en;
      en_prev <= en_q;
      rise_q  <= en_q & ~en_prev;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      SL         <= 1'b1;
      SCK        <= 1'b0;
      SDATA      <= 1'b0;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
      pending    <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      rem_mask   <= '0;
      snap_oper  <= '0;
      snap_ctrl  <= '0;
      snap_clamp <= '0;
      snap_gain  <= '0;
    end else begin
      cfg_done <= 1'b0;

      case (state)
        // DONE shares the start logic with IDLE so a pending request
        // launches its sequence on the cycle right after the done pulse.
        S_IDLE, S_DONE: begin
          if (rise_q || pending) begin
            pending    <= 1'b0;
            snap_oper  <= oper;
            snap_ctrl  <= ctrl;
            snap_clamp <= clamp;
            snap_gain  <= vga_gain;
            cfg_busy   <= 1'b1;
            if (cfg_mask == '0) begin
              state    <= S_DONE;
              cfg_done <= 1'b1;
            end else begin
              state    <= S_LOAD;
              rem_mask <= cfg_mask & ~(4'b0001 << start_addr);
              sr       <= start_word;
              SL       <= 1'b0;
              SCK      <= 1'b0;
              SDATA    <= start_word[0];
            end
          end else begin
            state    <= S_IDLE;
            cfg_busy <= 1'b0;
          end
        end

        S_LOAD: begin
          state   <= S_SHIFT;
          cnt     <= '0;
          bit_idx <= '0;
        end

        S_SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!SCK) begin
              SCK <= 1'b1;
            end else if (bit_idx == 4'd13) begin
              state <= S_HOLD;
              SCK   <= 1'b0;
              SDATA <= 1'b0;
            end else begin
              // Falling SCK and the next data bit leave on the same edge.
              SCK     <= 1'b0;
              SDATA   <= sr[1];
              sr      <= sr >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt == DIV_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
            SL    <= 1'b1;
            SDATA <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (rem_mask != '0) begin
              state    <= S_LOAD;
              rem_mask <= rem_mask & ~(4'b0001 << next_addr);
              sr       <= next_word;
              SL       <= 1'b0;
              SDATA    <= next_word[0];
            end else begin
              state    <= S_DONE;
              cfg_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state    <= S_IDLE;
          cfg_busy <= 1'b0;
          SL       <= 1'b1;
          SCK      <= 1'b0;
          SDATA    <= 1'b0;
        end
      endcase

      // One request may queue behind a running sequence; extra ones collapse.
      if (rise_q && (state != S_IDLE) && (state != S_DONE))
        pending <= 1'b1;
    end
  end

endmodule
